ucie_ctl_sb_tx_sched: RTL and testbench

//  Sideband TX scheduler: round-robin arbiter over NUM_REQ message sources plus beat sequencer.

---
 rtl/ucie_ctl_sb_tx_sched.sv | 171 +++++++++++++++++
 tb/tb_ucie_ctl_sb_tx_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_tx_sched.sv
// Sideband TX scheduler: round-robin arbitration over NUM_REQ sources and an N-bit beat sequencer.
// Optional post-packet idle gap is built only when UCIE_SB_IDLE_GAP_EN is defined.
module ucie_ctl_sb_tx_sched #(
    parameter int N         = 16,
    parameter int NUM_REQ   = 3,
    parameter int GAP_BEATS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ-1:0]    i_has_data,
    input  logic [NUM_REQ*64-1:0] i_hdr,
    input  logic [NUM_REQ*64-1:0] i_data,
    output logic [NUM_REQ-1:0]    o_grant,
    output logic                  o_tx_valid,
    output logic [N-1:0]          o_tx_data,
    input  logic                  i_tx_ready,
    output logic                  o_busy
);

    localparam int BPP = 64 / N;
    localparam int CW  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int PW  = $clog2(NUM_REQ);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BPP - 1);

    if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16 || N == 32)) begin : g_bad_n
        $error("ucie_ctl_sb_tx_sched: N must be 1, 2, 4, 8, 16 or 32");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("ucie_ctl_sb_tx_sched: NUM_REQ must be in 2..8");
    end
    if (GAP_BEATS < 1 || GAP_BEATS > 15) begin : g_bad_gap
        $error("ucie_ctl_sb_tx_sched: GAP_BEATS must be in 1..15");
    end

`ifdef UCIE_SB_IDLE_GAP_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;
    logic [3:0] gap_cnt;
`else
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   beat;
    logic [PW-1:0]   rr_ptr;
    logic [63:0]     hdr_sh;
    logic [63:0]     data_sh;
    logic            has_data_sh;

    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   next_ptr;
    logic [63:0]     hdr_arr  [NUM_REQ];
    logic [63:0]     data_arr [NUM_REQ];
    logic            accept;
    logic            last_beat;
    logic            eop;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            hdr_arr[k]  = i_hdr[k*64 +: 64];
            data_arr[k] = i_data[k*64 +: 64];
        end
    end

    // First requester at or after rr_ptr, wrapping, wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && i_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign next_ptr = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    assign o_grant  = (state == IDLE && found) ? (NUM_REQ'(1) << pick) : '0;

    assign accept    = o_tx_valid && i_tx_ready;
    assign last_beat = (beat == LAST_BEAT);
    assign eop       = accept && last_beat &&
                       ((state == DATA) || (state == HDR && !has_data_sh));

    // Shadow registers shift right by N per accepted beat, so the next beat is always bits [2N-1:N].
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            beat        <= '0;
            rr_ptr      <= '0;
            hdr_sh      <= '0;
            data_sh     <= '0;
            has_data_sh <= 1'b0;
            o_tx_valid  <= 1'b0;
            o_tx_data   <= '0;
            o_busy      <= 1'b0;
`ifdef UCIE_SB_IDLE_GAP_EN
            gap_cnt     <= '0;
`endif
        end else if (eop) begin
            beat       <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
`ifdef UCIE_SB_IDLE_GAP_EN
            state      <= GAP;
            gap_cnt    <= 4'(GAP_BEATS - 1);
            o_busy     <= 1'b1;
`else
            state      <= IDLE;
            o_busy     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= HDR;
                        beat        <= '0;
                        rr_ptr      <= next_ptr;
                        hdr_sh      <= hdr_arr[pick];
                        data_sh     <= data_arr[pick];
                        has_data_sh <= i_has_data[pick];
                        o_tx_valid  <= 1'b1;
                        o_tx_data   <= hdr_arr[pick][N-1:0];
                        o_busy      <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (last_beat) begin
                            state     <= DATA;
                            beat      <= '0;
                            o_tx_data <= data_sh[N-1:0];
                        end else begin
                            beat      <= beat + 1'b1;
                            hdr_sh    <= hdr_sh >> N;
                            o_tx_data <= hdr_sh[2*N-1:N];
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        beat      <= beat + 1'b1;
                        data_sh   <= data_sh >> N;
                        o_tx_data <= data_sh[2*N-1:N];
                    end
                end
`ifdef UCIE_SB_IDLE_GAP_EN
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    o_tx_valid <= 1'b0;
                    o_tx_data  <= '0;
                    o_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucie_ctl_sb_tx_sched.sv
// Scoreboard bench for ucie_ctl_sb_tx_sched (N=16, NUM_REQ=3); honours UCIE_SB_IDLE_GAP_EN if defined.
module tb_ucie_ctl_sb_tx_sched;

    localparam int N       = 16;
    localparam int NUM_REQ = 3;
`ifdef UCIE_SB_IDLE_GAP_EN
    localparam int EXP_GAP = 3;
`else
    localparam int EXP_GAP = 1;
`endif

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    has_data;
    logic [NUM_REQ*64-1:0] hdr;
    logic [NUM_REQ*64-1:0] data;
    logic [NUM_REQ-1:0]    grant;
    logic                  tx_valid;
    logic [N-1:0]          tx_data;
    logic                  tx_ready;
    logic                  busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int beat_count = 0;
    int last_beat_cyc = 0;
    bit have_last = 0;
    bit gap_chk = 0;

    logic [63:0]        hdr_m  [NUM_REQ];
    logic [63:0]        data_m [NUM_REQ];
    bit                 hd_m   [NUM_REQ];
    logic [N-1:0]       beat_q [$];
    logic [NUM_REQ-1:0] grant_q [$];

    ucie_ctl_sb_tx_sched #(.N(N), .NUM_REQ(NUM_REQ), .GAP_BEATS(2)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_req      (req),
        .i_has_data (has_data),
        .i_hdr      (hdr),
        .i_data     (data),
        .o_grant    (grant),
        .o_tx_valid (tx_valid),
        .o_tx_data  (tx_data),
        .i_tx_ready (tx_ready),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic loadSource(input int k, input logic [63:0] h, input logic [63:0] d, input bit hd);
        hdr_m[k]       = h;
        data_m[k]      = d;
        hd_m[k]        = hd;
        hdr[k*64 +: 64]  = h;
        data[k*64 +: 64] = d;
        has_data[k]      = hd;
    endtask

    // Queue the grant and up to max_beats beats that source k's packet should produce.
    task automatic expectPacket(input int k, input int max_beats);
        logic [63:0] h;
        logic [63:0] d;
        int pushed;
        h = hdr_m[k];
        d = data_m[k];
        pushed = 0;
        grant_q.push_back(NUM_REQ'(1) << k);
        for (int b = 0; b < 64 / N; b++) begin
            if (pushed < max_beats) beat_q.push_back(h[b*N +: N]);
            pushed++;
        end
        if (hd_m[k]) begin
            for (int b = 0; b < 64 / N; b++) begin
                if (pushed < max_beats) beat_q.push_back(d[b*N +: N]);
                pushed++;
            end
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input int n_grants);
        int seen;
        seen = 0;
        @(posedge clk); #1;
        req = mask;
        for (int c = 0; c < 400 && seen < n_grants; c++) begin
            @(negedge clk);
            if (grant != '0) seen++;
        end
        if (seen < n_grants) checkOutput("grant_timeout", 64'(seen), 64'(n_grants));
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (!busy && beat_q.size() == 0) done = 1;
        end
        if (!done) checkOutput("idle_timeout", 64'(beat_q.size()), 64'd0);
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!gap_chk) have_last = 0;
        if (!rst) begin
            if (grant != '0) begin
                if (grant_q.size() == 0) checkOutput("grant_unexp", 64'(grant_q.size()), 64'd1);
                else checkOutput("grant", 64'(grant), 64'(grant_q.pop_front()));
                checkOutput("grant_busy", 64'(busy), 64'd0);
                checkOutput("grant_valid", 64'(tx_valid), 64'd0);
                if (gap_chk && have_last) checkOutput("idle_gap", 64'(cyc - last_beat_cyc), 64'(EXP_GAP));
            end
            if (tx_valid && tx_ready) begin
                if (beat_q.size() == 0) checkOutput("beat_unexp", 64'(beat_q.size()), 64'd1);
                else checkOutput("beat", 64'(tx_data), 64'(beat_q.pop_front()));
                beat_count++;
                last_beat_cyc = cyc;
                have_last = 1;
            end
            if (!tx_valid) checkOutput("idle_data", 64'(tx_data), 64'd0);
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        bit hit;
        rst      = 1'b1;
        req      = '0;
        has_data = '0;
        hdr      = '0;
        data     = '0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_grant", 64'(grant), 64'd0);
        checkOutput("rst_valid", 64'(tx_valid), 64'd0);
        checkOutput("rst_data", 64'(tx_data), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] header-only packet from source 0");
        loadSource(0, 64'h1122334455667788, 64'h0, 1'b0);
        expectPacket(0, 99);
        applyStimulus(3'b001, 1);
        waitIdle();

        $display("[TB] header plus data from source 0");
        loadSource(0, 64'h1122334455667788, 64'hAABBCCDDEEFF0011, 1'b1);
        expectPacket(0, 99);
        applyStimulus(3'b001, 1);
        waitIdle();

        $display("[TB] all three requesting, round-robin order");
        applyReset();
        loadSource(0, 64'h0102030405060708, 64'h0, 1'b0);
        loadSource(1, 64'h1112131415161718, 64'h2122232425262728, 1'b1);
        loadSource(2, 64'h3132333435363738, 64'h0, 1'b0);
        expectPacket(0, 99);
        expectPacket(1, 99);
        expectPacket(2, 99);
        expectPacket(0, 99);
        gap_chk = 1;
        applyStimulus(3'b111, 4);
        waitIdle();
        gap_chk = 0;

        $display("[TB] backpressure on header beat 2");
        applyReset();
        loadSource(0, 64'h1122334455667788, 64'h0, 1'b0);
        expectPacket(0, 99);
        applyStimulus(3'b001, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkOutput("stall_data", 64'(tx_data), 64'h3344);
            checkOutput("stall_valid", 64'(tx_valid), 64'd1);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        waitIdle();

        $display("[TB] reset during data beat 1");
        applyReset();
        loadSource(1, 64'hCAFEF00D12345678, 64'h9ABCDEF013579BDF, 1'b1);
        loadSource(2, 64'h5555AAAA5555AAAA, 64'h0, 1'b0);
        expectPacket(1, 5);
        base = beat_count;
        applyStimulus(3'b010, 1);
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk); #2;
            if (beat_count == base + 5) hit = 1;
        end
        if (!hit) checkOutput("reset_wait", 64'(beat_count - base), 64'd5);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(tx_valid), 64'd0);
        checkOutput("midrst_data", 64'(tx_data), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_left", 64'(beat_q.size()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        expectPacket(1, 99);
        applyStimulus(3'b110, 1);
        waitIdle();

        repeat (3) @(negedge clk);
        checkOutput("sb_grant_empty", 64'(grant_q.size()), 64'd0);
        checkOutput("sb_beat_empty", 64'(beat_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
